// File: rtl/safe_obi_rr_arbiter_pkg.sv
// rtl/safe_obi_rr_arbiter_pkg.sv - shared types and constants for the safe OBI round-robin arbiter
package safe_obi_rr_arbiter_pkg;

    localparam int SAFE_ARB_NHARTS          = 3;
    localparam int SAFE_ARB_MAX_OUTSTANDING = 2;

    // Hart index for the default hart count; modules with other counts derive their own width.
    typedef logic [$clog2(SAFE_ARB_NHARTS)-1:0] hart_id_t;

    // OBI data-port request as issued by a core or forwarded to the system bus.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    // OBI data-port response as returned by the system bus or routed to a core.
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Index width that stays at least one bit for degenerate counts.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/safe_arb_id_fifo.sv
// rtl/safe_arb_id_fifo.sv - synchronous FIFO of granted hart IDs
module safe_arb_id_fifo
    import safe_obi_rr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = id_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status flags and head entry straight from the registered state.
    always_comb begin
        full_o  = (count_q == CW'(DEPTH));
        empty_o = (count_q == '0);
        head_o  = mem_q[rd_ptr_q];
    end

    // Next-state: overflowing pushes and underflowing pops are ignored here; the caller flags them.
    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // State registers; reset discards all entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/safe_obi_rr_arbiter.sv
// rtl/safe_obi_rr_arbiter.sv - round-robin / single-bus sharing of the system OBI data port
module safe_obi_rr_arbiter
    import safe_obi_rr_arbiter_pkg::*;
#(
    parameter int NHARTS          = SAFE_ARB_NHARTS,
    parameter int MAX_OUTSTANDING = SAFE_ARB_MAX_OUTSTANDING
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              single_bus_i,
    input  logic [NHARTS-1:0] master_core_i,
    input  obi_req_t          core_req_i  [NHARTS],
    output obi_resp_t         core_resp_o [NHARTS],
    output obi_req_t          bus_req_o,
    input  obi_resp_t         bus_resp_i,
    output logic              mode_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int IDW = id_width(NHARTS);
    typedef logic [IDW-1:0] id_t;
    localparam id_t LAST_ID = id_t'(NHARTS - 1);

    id_t  rr_q, rr_d;
    logic lock_q, lock_d;
    id_t  lock_id_q, lock_id_d;
    logic mode_q, mode_d;
    logic err_q, err_d;

    id_t  rr_sel;
    logic rr_found;
    id_t  master_sel;
    id_t  sel;
    logic handshake;
    logic rsp_ok;
    logic fifo_push;
    logic fifo_full;
    logic fifo_empty;
    id_t  fifo_head;

    // Round-robin search: first requesting hart at or after the pointer, wrapping.
    always_comb begin
        rr_sel   = rr_q;
        rr_found = 1'b0;
        for (int i = 0; i < NHARTS; i++) begin
            if (!rr_found && core_req_i[(int'(rr_q) + i) % NHARTS].req) begin
                rr_found = 1'b1;
                rr_sel   = id_t'((int'(rr_q) + i) % NHARTS);
            end
        end
    end

    // Master-core decode; anything other than a single set bit falls back to hart 0.
    always_comb begin
        master_sel = '0;
        if ($onehot(master_core_i)) begin
            for (int i = 0; i < NHARTS; i++) begin
                if (master_core_i[i]) begin
                    master_sel = id_t'(i);
                end
            end
        end
    end

    // Forwarding and response steering for the mode currently in effect.
    always_comb begin
        sel       = mode_q ? master_sel : (lock_q ? lock_id_q : rr_sel);
        bus_req_o = core_req_i[sel];
        if (!mode_q && fifo_full) begin
            bus_req_o.req = 1'b0;
        end
        handshake = bus_req_o.req & bus_resp_i.gnt;
        fifo_push = handshake & ~fifo_full;
        rsp_ok    = bus_resp_i.rvalid & ~fifo_empty;

        for (int h = 0; h < NHARTS; h++) begin
            core_resp_o[h] = '0;
        end
        if (mode_q) begin
            for (int h = 0; h < NHARTS; h++) begin
                core_resp_o[h].gnt    = bus_resp_i.gnt;
                core_resp_o[h].rvalid = rsp_ok;
                core_resp_o[h].rdata  = rsp_ok ? bus_resp_i.rdata : '0;
            end
        end else begin
            core_resp_o[sel].gnt = bus_resp_i.gnt & ~fifo_full;
            if (rsp_ok) begin
                core_resp_o[fifo_head].rvalid = 1'b1;
                core_resp_o[fifo_head].rdata  = bus_resp_i.rdata;
            end
        end
    end

    // Next state: mode only moves when the bus is quiet, lock holds a stalled request steady.
    always_comb begin
        mode_d    = (fifo_empty && !handshake) ? single_bus_i : mode_q;
        rr_d      = rr_q;
        lock_d    = 1'b0;
        lock_id_d = lock_id_q;
        err_d     = err_q | (bus_resp_i.rvalid & fifo_empty);
        if (!mode_q) begin
            if (handshake) begin
                rr_d = (sel == LAST_ID) ? '0 : sel + 1'b1;
            end
            if (core_req_i[sel].req && !handshake) begin
                lock_d    = 1'b1;
                lock_id_d = sel;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
        end
    end

    safe_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (sel),
        .pop_i   (rsp_ok),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign mode_o = mode_q;
    assign busy_o = ~fifo_empty;
    assign err_o  = err_q;

endmodule

// File: tb/tb_safe_obi_rr_arbiter.sv
// tb/tb_safe_obi_rr_arbiter.sv - self-checking bench for safe_obi_rr_arbiter
module tb_safe_obi_rr_arbiter;
    import safe_obi_rr_arbiter_pkg::*;

    localparam int NH   = 3;
    localparam int MAXO = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            single_bus;
    logic [NH-1:0]   master_core;
    obi_req_t        core_req  [NH];
    obi_resp_t       core_resp [NH];
    obi_req_t        bus_req;
    obi_resp_t       bus_resp;
    logic            mode, busy, err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_rr;
    int m_lock;
    bit m_mode;
    bit m_err;
    int m_q[$];
    int e_sel;
    bit e_hs;

    typedef struct {
        logic [NH-1:0] master;
        int            exp_hart;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    safe_obi_rr_arbiter #(.NHARTS(NH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .single_bus_i  (single_bus),
        .master_core_i (master_core),
        .core_req_i    (core_req),
        .core_resp_o   (core_resp),
        .bus_req_o     (bus_req),
        .bus_resp_i    (bus_resp),
        .mode_o        (mode),
        .busy_o        (busy),
        .err_o         (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] hart_addr(input int h);
        return 32'h1000_0000 + 32'(h) * 32'h100;
    endfunction

    task automatic set_req(input int h, input bit r, input logic [31:0] a);
        core_req[h].req   = r;
        core_req[h].we    = 1'b0;
        core_req[h].be    = 4'hF;
        core_req[h].addr  = a;
        core_req[h].wdata = a ^ 32'h5555_5555;
    endtask

    task automatic idle_inputs();
        for (int h = 0; h < NH; h++) set_req(h, 1'b0, 32'h0);
        bus_resp = '0;
    endtask

    // Compares every DUT output against what the rules demand for the current inputs.
    task automatic model_check();
        bit full, empty, rsp, exp_rv;
        int sel;
        bit e_req;
        full  = (m_q.size() >= MAXO);
        empty = (m_q.size() == 0);
        if (m_mode) begin
            sel = 0;
            if ($countones(master_core) == 1)
                for (int i = 0; i < NH; i++) if (master_core[i]) sel = i;
            e_req = core_req[sel].req;
        end else begin
            if (m_lock >= 0) sel = m_lock;
            else begin
                sel = -1;
                for (int k = 0; k < NH; k++) begin
                    int h;
                    h = (m_rr + k) % NH;
                    if (sel < 0 && core_req[h].req) sel = h;
                end
                if (sel < 0) sel = m_rr;
            end
            e_req = core_req[sel].req && !full;
        end
        e_sel = sel;
        e_hs  = e_req && bus_resp.gnt;
        rsp   = bus_resp.rvalid && !empty;
        check_bit("bus_req", bus_req.req, e_req);
        if (e_req) check("bus_addr", bus_req.addr, core_req[sel].addr);
        for (int h = 0; h < NH; h++) begin
            if (m_mode) begin
                check_bit("bcast_gnt", core_resp[h].gnt, bus_resp.gnt);
                check_bit("bcast_rvalid", core_resp[h].rvalid, rsp);
                if (rsp) check("bcast_rdata", core_resp[h].rdata, bus_resp.rdata);
            end else begin
                if (core_req[h].req)
                    check_bit("rr_gnt", core_resp[h].gnt, (h == sel) && bus_resp.gnt && !full);
                exp_rv = 1'b0;
                if (rsp) exp_rv = (m_q[0] == h);
                check_bit("rr_rvalid", core_resp[h].rvalid, exp_rv);
                if (exp_rv) check("rr_rdata", core_resp[h].rdata, bus_resp.rdata);
            end
        end
        check_bit("mode", mode, m_mode);
        check_bit("busy", busy, m_q.size() != 0);
        check_bit("err", err, m_err);
    endtask

    task automatic model_update();
        bit empty, full, old_mode;
        empty    = (m_q.size() == 0);
        full     = (m_q.size() >= MAXO);
        old_mode = m_mode;
        if (bus_resp.rvalid) begin
            if (empty) m_err = 1'b1;
            else void'(m_q.pop_front());
        end
        if (e_hs && !full) m_q.push_back(e_sel);
        if (empty && !e_hs) m_mode = single_bus;
        if (!old_mode) begin
            if (e_hs) m_rr = (e_sel + 1) % NH;
            m_lock = (core_req[e_sel].req && !e_hs) ? e_sel : -1;
        end else begin
            m_lock = -1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        single_bus  = 1'b0;
        master_core = 3'b001;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_mode", mode, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_bit("rst_bus_req", bus_req.req, 1'b0);
        check("rst_bus_addr", bus_req.addr, 32'h0);
        for (int h = 0; h < NH; h++) begin
            check_bit("rst_gnt", core_resp[h].gnt, 1'b0);
            check_bit("rst_rvalid", core_resp[h].rvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_rr   = 0;
        m_lock = -1;
        m_mode = 1'b0;
        m_err  = 1'b0;
        m_q.delete();
    endtask

    // Returns every outstanding response with no new requests, bounded by a cycle budget.
    task automatic drain();
        int guard;
        guard = 0;
        for (int h = 0; h < NH; h++) set_req(h, 1'b0, hart_addr(h));
        bus_resp.gnt = 1'b0;
        while (m_q.size() > 0 && guard < 20) begin
            bus_resp.rvalid = 1'b1;
            bus_resp.rdata  = $urandom;
            sample();
            advance();
            guard++;
        end
        check_bit("drain_done", m_q.size() == 0, 1'b1);
        bus_resp = '0;
    endtask

    initial begin
        int prev;
        bit pend [NH];

        tbl[0] = '{3'b001, 0};
        tbl[1] = '{3'b010, 1};
        tbl[2] = '{3'b100, 2};
        tbl[3] = '{3'b000, 0};
        tbl[4] = '{3'b011, 0};
        tbl[5] = '{3'b110, 0};
        tbl[6] = '{3'b111, 0};

        // Round-robin rotation with tagged read data
        do_reset();
        prev = -1;
        for (int c = 0; c < 6; c++) begin
            for (int h = 0; h < NH; h++) set_req(h, 1'b1, hart_addr(h));
            bus_resp.gnt    = 1'b1;
            bus_resp.rvalid = (prev >= 0);
            bus_resp.rdata  = 32'hA0 + 32'(prev);
            sample();
            check_bit("t1_gnt_order", core_resp[c % NH].gnt, 1'b1);
            if (prev >= 0) begin
                check_bit("t1_rvalid", core_resp[prev].rvalid, 1'b1);
                check("t1_rdata", core_resp[prev].rdata, 32'hA0 + 32'(prev));
            end
            advance();
            prev = c % NH;
        end
        drain();

        // Outstanding limit with read data withheld
        do_reset();
        for (int h = 0; h < NH; h++) set_req(h, 1'b1, hart_addr(h));
        bus_resp.gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus_resp.rvalid = (c == 4);
            bus_resp.rdata  = 32'hB0;
            sample();
            if (c < 2) check_bit("t2_gnt", core_resp[c].gnt, 1'b1);
            if (c >= 2 && c <= 4) begin
                check_bit("t2_req_blocked", bus_req.req, 1'b0);
                check_bit("t2_busy", busy, 1'b1);
            end
            if (c == 4) begin
                check_bit("t2_rvalid_first", core_resp[0].rvalid, 1'b1);
                check("t2_rdata_first", core_resp[0].rdata, 32'hB0);
            end
            if (c == 5) check_bit("t2_third_gnt", core_resp[2].gnt, 1'b1);
            advance();
        end
        drain();

        // Stalled request keeps its address while a competitor waits
        do_reset();
        set_req(1, 1'b1, 32'h0000_1111);
        bus_resp.gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_req(2, 1'b1, 32'h0000_2222);
            sample();
            check("t3_stall_addr", bus_req.addr, 32'h0000_1111);
            advance();
        end
        bus_resp.gnt = 1'b1;
        sample();
        check_bit("t3_h1_first", core_resp[1].gnt, 1'b1);
        advance();
        set_req(1, 1'b0, 32'h0);
        sample();
        check_bit("t3_h2_next", core_resp[2].gnt, 1'b1);
        advance();
        drain();

        // Mode switch waits for the outstanding transaction
        do_reset();
        set_req(0, 1'b1, hart_addr(0));
        bus_resp.gnt = 1'b1;
        sample();
        advance();
        set_req(0, 1'b0, hart_addr(0));
        bus_resp.gnt = 1'b0;
        single_bus   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sample();
            check_bit("t4_mode_held", mode, 1'b0);
            advance();
        end
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hC0;
        sample();
        check_bit("t4_mode_at_pop", mode, 1'b0);
        check_bit("t4_rvalid", core_resp[0].rvalid, 1'b1);
        advance();
        bus_resp.rvalid = 1'b0;
        sample();
        advance();
        sample();
        check_bit("t4_mode_switched", mode, 1'b1);
        advance();

        // Single-bus master decode table
        for (int h = 0; h < NH; h++) set_req(h, 1'b1, 32'h2000 + 32'(h) * 32'h10);
        for (int i = 0; i < 7; i++) begin
            master_core = tbl[i].master;
            sample();
            check("t5_master_addr", bus_req.addr, 32'h2000 + 32'(tbl[i].exp_hart) * 32'h10);
            advance();
        end

        // Single-bus broadcast of grant and read data
        master_core  = 3'b010;
        bus_resp.gnt = 1'b1;
        sample();
        check("t5_bus_addr", bus_req.addr, 32'h2010);
        for (int h = 0; h < NH; h++) check_bit("t5_bcast_gnt", core_resp[h].gnt, 1'b1);
        advance();
        for (int h = 0; h < NH; h++) set_req(h, 1'b0, 32'h0);
        bus_resp.gnt    = 1'b0;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hDEAD_BEEF;
        sample();
        for (int h = 0; h < NH; h++) begin
            check_bit("t5_bcast_rvalid", core_resp[h].rvalid, 1'b1);
            check("t5_bcast_rdata", core_resp[h].rdata, 32'hDEAD_BEEF);
        end
        advance();
        bus_resp = '0;

        // Spurious read data with nothing outstanding
        do_reset();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'h5A5A;
        sample();
        for (int h = 0; h < NH; h++) check_bit("t6_no_rvalid", core_resp[h].rvalid, 1'b0);
        advance();
        bus_resp.rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            check_bit("t6_err_sticky", err, 1'b1);
            advance();
        end
        do_reset();
        check_bit("t6_err_cleared", err, 1'b0);

        // Randomised traffic against the reference model
        do_reset();
        for (int h = 0; h < NH; h++) pend[h] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int h = 0; h < NH; h++) begin
                if (!pend[h] && ($urandom_range(0, 1) == 1)) begin
                    set_req(h, 1'b1, $urandom);
                    pend[h] = 1'b1;
                end else if (!pend[h]) begin
                    set_req(h, 1'b0, core_req[h].addr);
                end
            end
            bus_resp.gnt    = ($urandom_range(0, 3) != 0);
            bus_resp.rvalid = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                               : ($urandom_range(0, 99) == 0);
            bus_resp.rdata  = $urandom;
            if ($urandom_range(0, 39) == 0) single_bus = ~single_bus;
            if ($urandom_range(0, 19) == 0) master_core = 3'($urandom_range(0, 7));
            sample();
            if (e_hs) begin
                if (m_mode) begin
                    for (int h = 0; h < NH; h++) pend[h] = 1'b0;
                end else begin
                    pend[e_sel] = 1'b0;
                end
            end
            advance();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/safe_obi_rr_arbiter.md
Name: safe_obi_rr_arbiter

Overview:
- Shares the single system-bus OBI data port between NHARTS cores when the wrapper runs in non-lockstep mode.
- Arbitration is round-robin. A FIFO of granted hart IDs tracks outstanding transactions and steers each rvalid back to the hart that issued it.
- In single-bus (safe/lockstep) mode it forwards only the master core and broadcasts gnt, rvalid and rdata to all harts.
- Sits between the per-core CPU xbars (slave[0]) and the external data ports of the safe CPU wrapper.

Parameters:
- NHARTS, 3, number of requesting cores (2..8).
- MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (power of two, ≥1).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- single_bus_i  input  1  requested mode: 1 = single-bus safe mode, 0 = shared round-robin mode.
- master_core_i  input  NHARTS  one-hot master core select for single-bus mode.
- core_req_i  input  obi_req_t[NHARTS]  per-hart OBI requests.
- core_resp_o  output  obi_resp_t[NHARTS]  per-hart OBI responses.
- bus_req_o  output  obi_req_t  request to the system bus.
- bus_resp_i  input  obi_resp_t  response from the system bus.
- mode_o  output  1  effective (registered) mode currently applied.
- busy_o  output  1  FIFO non-empty, i.e. transactions outstanding.
- err_o  output  1  sticky flag: rvalid received while the FIFO was empty.

Behaviour:
- Reset values:
  - rr pointer = 0, FIFO empty, lock = 0.
  - mode_o = 0, busy_o = 0, err_o = 0.
  - bus_req_o = '0, all core_resp_o = '0.
- Mode register:
  - mode_o loads single_bus_i only on cycles where the FIFO is empty and no handshake is occurring; otherwise it holds.
  - A mode change therefore never splits an outstanding transaction.
- Shared mode (mode_o = 0), selection:
  - Selected hart = first requesting hart at or after rr pointer, wrapping modulo NHARTS.
  - If lock = 1, the selection is the locked hart instead.
- Shared mode, request forwarding:
  - bus_req_o = core_req_i[sel] when FIFO not full; otherwise bus_req_o.req = 0.
  - Address, we, be and wdata follow the selected hart.
- Shared mode, grant and lock:
  - core_resp_o[sel].gnt = bus_resp_i.gnt & ~full. gnt is combinational, zero added latency.
  - lock sets when the selected req is high and not granted, and clears on that handshake. This preserves OBI request stability.
- Shared mode, on handshake (req & gnt):
  - Push sel into the FIFO.
  - rr pointer <= sel+1, wrapping at NHARTS.
- Shared mode, response routing:
  - On bus_resp_i.rvalid, drive rvalid/rdata to the hart at the FIFO head in the same cycle, then pop.
  - All other harts see rvalid = 0.
- Single-bus mode (mode_o = 1):
  - sel = index of master_core_i. If master_core_i is zero or not one-hot, hart 0 is used.
  - bus_req_o = core_req_i[sel].
  - gnt, rvalid and rdata from bus_resp_i are broadcast to every hart.
  - FIFO push/pop continue with ID = sel, for busy_o only.
- FIFO boundaries:
  - A push and a pop in the same cycle are allowed when the FIFO is neither full nor empty; the count is unchanged.
  - When the FIFO is full, grant is blocked even if a pop occurs that cycle.
  - A pop on an empty FIFO sets err_o, does not change the pointer, and forwards no rvalid.
- err_o clears only on reset.
- An asynchronous reset mid-transaction discards all FIFO contents and the lock.

Decomposition:
- Shared package cei_mochila_pkg gains:
  - SAFE_ARB_MAX_OUTSTANDING constant.
  - hart_id_t = logic [$clog2(NHARTS)-1:0].
- The existing obi_pkg types are reused.
- Sub-module: safe_arb_id_fifo. It is a synchronous FIFO with push, pop, full, empty and head, parameterised on depth and width.
- The round-robin select and the mode logic stay in the top module.

Test Plan:
1. Shared mode: harts 0, 1 and 2 request continuously with bus gnt = 1 and rvalid one cycle after grant → grants go 0, 1, 2, 0…. Each hart receives its own rdata (0xA0, 0xA1, 0xA2 tagged).
2. Shared mode, MAX_OUTSTANDING = 2, rvalid withheld:
   - Expected: two grants, then req stays low and busy_o = 1.
   - Release one rvalid → it routes to the first ID, then the third grant issues.
3. Stall: hart 1 requests, bus gnt held at 0 for 4 cycles while hart 2 also requests → the bus address stays hart 1's for all 4 cycles. Hart 1 is granted first, then hart 2.
4. Mode switch with 1 outstanding: single_bus_i rises → mode_o stays 0 until that rvalid pops. It then goes to 1 on the next cycle.
5. Single-bus mode with master_core_i = 3'b010: all harts request → only hart 1's address reaches the bus. All three harts see identical gnt/rvalid/rdata = 0xDEADBEEF.
6. Spurious rvalid with the FIFO empty → err_o = 1, no core rvalid. err_o stays 1 until rst_ni is pulsed low.
